// File: rtl/unibus_mem_slave_pkg.sv
// Shared definitions for the Unibus memory slave: bus function codes, FSM states
// and the byte-lane parity helpers used on the 18-bit external memory.
package unibus_mem_slave_pkg;

    typedef enum logic [1:0] {
        FN_DATI  = 2'b00,
        FN_DATIP = 2'b01,
        FN_DATO  = 2'b10,
        FN_DATOB = 2'b11
    } func_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEMRD,
        ST_RDLAT,
        ST_MEMWR,
        ST_DRIVE,
        ST_SSYN,
        ST_RELEASE
    } state_t;

    // Parity bit that makes the 9-bit lane {par, byte} contain an odd number of ones.
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic lane_par_bad(input logic [8:0] lane);
        return ~^lane;
    endfunction

endpackage

// File: rtl/unibus_sync2.sv
// Two-flop synchronizer for asynchronous bus control lines into the CLOCK domain.
module unibus_sync2 #(
    parameter int W = 1
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/unibus_mem_slave.sv
// Unibus main-memory slave: decodes MSYN cycles below the I/O page, runs DATI/DATIP/
// DATO/DATOB against an 18-bit registered RAM and answers with data, parity and SSYN.
module unibus_mem_slave
    import unibus_mem_slave_pkg::*;
#(
    parameter logic [17:0] MEMTOP  = 18'o760000,
    parameter int          SSYNDLY = 5
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic        paren,
    input  logic        init_in_h,
    input  logic        msyn_in_h,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    output logic [15:0] d_out_h,
    output logic        pa_out_h,
    output logic        pb_out_h,
    output logic        ssyn_out_h,
    output logic [16:0] extmemaddr,
    output logic [17:0] extmemdout,
    input  logic [17:0] extmemdin,
    output logic        extmemenab,
    output logic [1:0]  extmemwena,
    output logic [15:0] parerrcnt
);

    logic msyn_s;
    logic init_s;

    unibus_sync2 #(.W(2)) u_sync (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .d       ({init_in_h, msyn_in_h}),
        .q       ({init_s, msyn_s})
    );

    state_t      state_reg, state_next;
    logic [17:0] addr_reg;
    func_t       func_reg;
    logic [15:0] wdata_reg;
    logic [15:0] rdata_reg;
    logic        perr_reg;
    logic [7:0]  cnt_reg, cnt_next;
    logic [15:0] parerrcnt_reg;
    logic        need_low_reg;
    logic        accept;
    logic        rd_err;
    logic        drive_rd;

    assign rd_err = lane_par_bad(extmemdin[8:0]) | lane_par_bad(extmemdin[17:9]);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        if (init_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (msyn_s && !need_low_reg && enable && !init_in_h && (a_in_h < MEMTOP)) begin
                        accept     = 1'b1;
                        state_next = c_in_h[1] ? ST_MEMWR : ST_MEMRD;
                    end
                end
                ST_MEMRD:   state_next = ST_RDLAT;
                // An aborted cycle still completes its RAM access but never raises SSYN.
                ST_RDLAT:   state_next = msyn_s ? ST_DRIVE : ST_RELEASE;
                ST_MEMWR:   state_next = msyn_s ? ST_DRIVE : ST_RELEASE;
                ST_DRIVE: begin
                    if (!msyn_s)
                        state_next = ST_RELEASE;
                    else if (cnt_reg == 8'(SSYNDLY - 1))
                        state_next = ST_SSYN;
                end
                ST_SSYN:    if (!msyn_s) state_next = ST_RELEASE;
                ST_RELEASE: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    assign cnt_next = (state_reg == ST_DRIVE && state_next == ST_DRIVE) ? cnt_reg + 8'd1 : 8'd0;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            func_reg      <= FN_DATI;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            perr_reg      <= 1'b0;
            cnt_reg       <= '0;
            parerrcnt_reg <= '0;
            need_low_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg  <= a_in_h;
                func_reg  <= func_t'(c_in_h);
                wdata_reg <= d_in_h;
            end
            if (state_reg == ST_RDLAT) begin
                rdata_reg <= {extmemdin[16:9], extmemdin[7:0]};
                perr_reg  <= paren & rd_err;
            end
            if (state_reg == ST_RDLAT && state_next == ST_DRIVE && paren && rd_err &&
                parerrcnt_reg != 16'hFFFF)
                parerrcnt_reg <= parerrcnt_reg + 16'd1;
            // After INIT a still-asserted MSYN belongs to the cancelled cycle.
            if (init_s && msyn_s)
                need_low_reg <= 1'b1;
            else if (!msyn_s)
                need_low_reg <= 1'b0;
        end
    end

    assign drive_rd   = (state_reg == ST_DRIVE || state_reg == ST_SSYN) && !func_reg[1];
    assign d_out_h    = drive_rd ? rdata_reg : 16'd0;
    assign pa_out_h   = drive_rd & perr_reg;
    assign pb_out_h   = drive_rd & perr_reg;
    assign ssyn_out_h = (state_reg == ST_SSYN);
    assign parerrcnt  = parerrcnt_reg;

    assign extmemaddr = addr_reg[17:1];
    assign extmemenab = (state_reg == ST_MEMRD) || (state_reg == ST_MEMWR);

    always_comb begin
        extmemwena = 2'b00;
        extmemdout = '0;
        if (state_reg == ST_MEMWR) begin
            extmemdout = {odd_par(wdata_reg[15:8]), wdata_reg[15:8],
                          odd_par(wdata_reg[7:0]),  wdata_reg[7:0]};
            if (func_reg == FN_DATOB)
                extmemwena = addr_reg[0] ? 2'b10 : 2'b01;
            else
                extmemwena = 2'b11;
        end
    end

endmodule

// File: tb/tb_unibus_mem_slave.sv
// Self-checking bench for unibus_mem_slave: directed vector table, hand-written
// INIT/hold/abort sequences and randomized cycles against a word-level memory model.
module tb_unibus_mem_slave;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        enable, paren, init_in_h, msyn_in_h;
    logic [17:0] a_in_h;
    logic [1:0]  c_in_h;
    logic [15:0] d_in_h;
    logic [15:0] d_out_h;
    logic        pa_out_h, pb_out_h, ssyn_out_h;
    logic [16:0] extmemaddr;
    logic [17:0] extmemdout;
    logic [17:0] extmemdin;
    logic        extmemenab;
    logic [1:0]  extmemwena;
    logic [15:0] parerrcnt;

    always #5 CLOCK = ~CLOCK;

    unibus_mem_slave dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .enable     (enable),
        .paren      (paren),
        .init_in_h  (init_in_h),
        .msyn_in_h  (msyn_in_h),
        .a_in_h     (a_in_h),
        .c_in_h     (c_in_h),
        .d_in_h     (d_in_h),
        .d_out_h    (d_out_h),
        .pa_out_h   (pa_out_h),
        .pb_out_h   (pb_out_h),
        .ssyn_out_h (ssyn_out_h),
        .extmemaddr (extmemaddr),
        .extmemdout (extmemdout),
        .extmemdin  (extmemdin),
        .extmemenab (extmemenab),
        .extmemwena (extmemwena),
        .parerrcnt  (parerrcnt)
    );

    // External registered RAM with a bench-side preload port.
    logic [17:0] mem [0:131071];
    logic        pre_we;
    logic [16:0] pre_addr;
    logic [17:0] pre_data;

    always @(posedge CLOCK) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (extmemenab) begin
            if (extmemwena[0]) mem[extmemaddr][8:0]  <= extmemdout[8:0];
            if (extmemwena[1]) mem[extmemaddr][17:9] <= extmemdout[17:9];
        end
        if (extmemenab) extmemdin <= mem[extmemaddr];
    end

    int         enab_total = 0;
    int         ssyn_rises = 0;
    logic       ssyn_prev  = 1'b0;
    logic [1:0] last_wena  = 2'b00;

    always @(posedge CLOCK) begin
        if (extmemenab) begin
            enab_total <= enab_total + 1;
            last_wena  <= extmemwena;
        end
        ssyn_prev <= ssyn_out_h;
        if (ssyn_out_h && !ssyn_prev) ssyn_rises <= ssyn_rises + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    function automatic logic [17:0] mkword(input logic [15:0] d);
        return {~^d[15:8], d[15:8], ~^d[7:0], d[7:0]};
    endfunction

    task automatic preload(input logic [16:0] wa, input logic [17:0] w);
        @(negedge CLOCK);
        pre_we = 1'b1; pre_addr = wa; pre_data = w;
        @(negedge CLOCK);
        pre_we = 1'b0;
    endtask

    // Results of the last bus cycle.
    logic        r_got, r_pa, r_pb, r_idle_ok;
    logic [15:0] r_d;
    logic [1:0]  r_wena;
    int          r_lat, r_nenab;
    logic [15:0] hist [0:31];

    task automatic bus_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                             input logic p, input logic en);
        int e0;
        @(negedge CLOCK);
        a_in_h = a; c_in_h = c; d_in_h = d; paren = p; enable = en;
        e0 = enab_total;
        r_got = 1'b0; r_lat = 0; r_d = '0; r_pa = 1'b0; r_pb = 1'b0;
        msyn_in_h = 1'b1;
        for (int i = 1; i < 32; i++) begin
            @(negedge CLOCK);
            hist[i] = d_out_h;
            if (ssyn_out_h) begin
                r_got = 1'b1; r_lat = i; r_d = d_out_h; r_pa = pa_out_h; r_pb = pb_out_h;
                break;
            end
        end
        msyn_in_h = 1'b0;
        repeat (6) @(negedge CLOCK);
        r_nenab   = enab_total - e0;
        r_wena    = last_wena;
        r_idle_ok = !ssyn_out_h && d_out_h == 16'd0 && !pa_out_h && !pb_out_h;
        enable    = 1'b1;
    endtask

    typedef struct {
        logic [17:0] a;
        logic [1:0]  c;
        logic [15:0] d;
        logic        p;
        logic        en;
        logic        exp_ssyn;
        logic [15:0] exp_d;
        logic        exp_pa;
        int          exp_enab;
        logic [1:0]  exp_wena;
        int          exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                                input logic p, input logic en, input logic s, input logic [15:0] xd,
                                input logic xpa, input int xe, input logic [1:0] xw, input int xerr);
        vec_t v;
        v.a = a; v.c = c; v.d = d; v.p = p; v.en = en; v.exp_ssyn = s; v.exp_d = xd;
        v.exp_pa = xpa; v.exp_enab = xe; v.exp_wena = xw; v.exp_err = xerr;
        return v;
    endfunction

    localparam int NV = 15;
    vec_t        tv [NV];
    logic [15:0] ref_word [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e0, r0, k;
        logic dropped;
        vec_t v;

        RESET_N = 1'b0; enable = 1'b1; paren = 1'b1; init_in_h = 1'b0; msyn_in_h = 1'b0;
        a_in_h = '0; c_in_h = '0; d_in_h = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        preload(17'o200, {1'b1, 8'h00, 1'b0, 8'h55});
        preload(17'(18'o757776 >> 1), mkword(16'o012345));
        for (int i = 0; i < 16; i++) begin
            ref_word[i] = 16'($urandom);
            preload(17'o1000 + 17'(i), mkword(ref_word[i]));
        end

        @(negedge CLOCK);
        chk("rst_ssyn", ssyn_out_h, 0);
        chk("rst_dout", d_out_h, 0);
        chk("rst_papb", {pa_out_h, pb_out_h}, 0);
        chk("rst_enab", extmemenab, 0);
        chk("rst_wena", extmemwena, 0);
        chk("rst_memout", {extmemaddr, extmemdout}, 0);
        chk("rst_errcnt", parerrcnt, 0);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK);

        tv[0]  = mk(18'o001000, 2'b10, 16'o123456, 1, 1, 1, 16'o000000, 0, 1, 2'b11, 0);
        tv[1]  = mk(18'o001000, 2'b00, 16'o000000, 1, 1, 1, 16'o123456, 0, 1, 2'b00, 0);
        tv[2]  = mk(18'o001000, 2'b10, 16'o125252, 1, 1, 1, 16'o000000, 0, 1, 2'b11, 0);
        tv[3]  = mk(18'o001001, 2'b11, 16'o177777, 1, 1, 1, 16'o000000, 0, 1, 2'b10, 0);
        tv[4]  = mk(18'o001000, 2'b00, 16'o000000, 1, 1, 1, 16'o177652, 0, 1, 2'b00, 0);
        tv[5]  = mk(18'o001000, 2'b11, 16'o000111, 1, 1, 1, 16'o000000, 0, 1, 2'b01, 0);
        tv[6]  = mk(18'o001001, 2'b00, 16'o000000, 1, 1, 1, 16'o177511, 0, 1, 2'b00, 0);
        tv[7]  = mk(18'o000400, 2'b00, 16'o000000, 1, 1, 1, 16'o000125, 1, 1, 2'b00, 1);
        tv[8]  = mk(18'o000400, 2'b00, 16'o000000, 0, 1, 1, 16'o000125, 0, 1, 2'b00, 1);
        tv[9]  = mk(18'o760000, 2'b00, 16'o000000, 1, 1, 0, 16'o000000, 0, 0, 2'b00, 1);
        tv[10] = mk(18'o777776, 2'b00, 16'o000000, 1, 1, 0, 16'o000000, 0, 0, 2'b00, 1);
        tv[11] = mk(18'o757776, 2'b01, 16'o000000, 1, 1, 1, 16'o012345, 0, 1, 2'b00, 1);
        tv[12] = mk(18'o757776, 2'b10, 16'o054321, 1, 1, 1, 16'o000000, 0, 1, 2'b11, 1);
        tv[13] = mk(18'o757776, 2'b00, 16'o000000, 1, 1, 1, 16'o054321, 0, 1, 2'b00, 1);
        tv[14] = mk(18'o001000, 2'b00, 16'o000000, 1, 0, 0, 16'o000000, 0, 0, 2'b00, 1);

        for (int i = 0; i < NV; i++) begin
            v = tv[i];
            bus_cycle(v.a, v.c, v.d, v.p, v.en);
            chk($sformatf("v%0d_ssyn", i), r_got, v.exp_ssyn);
            chk($sformatf("v%0d_enab", i), r_nenab, v.exp_enab);
            chk($sformatf("v%0d_errcnt", i), parerrcnt, v.exp_err);
            chk($sformatf("v%0d_release", i), r_idle_ok, 1);
            if (v.exp_ssyn) begin
                chk($sformatf("v%0d_lat", i), r_lat, v.c[1] ? 9 : 10);
                chk($sformatf("v%0d_data", i), r_d, v.exp_d);
                chk($sformatf("v%0d_pa", i), r_pa, v.exp_pa);
                chk($sformatf("v%0d_pb", i), r_pb, v.exp_pa);
                if (!v.c[1] && r_lat > 5)
                    chk($sformatf("v%0d_predrive", i), hist[r_lat - 5], v.exp_d);
            end
            if (v.exp_enab != 0)
                chk($sformatf("v%0d_wena", i), r_wena, v.exp_wena);
            $display("vec %0d a=%06o c=%0d -> ssyn=%0d d=%06o pa=%0d lat=%0d", i, v.a, v.c, r_got, r_d, r_pa, r_lat);
        end

        // INIT while SSYN is asserted.
        @(negedge CLOCK);
        a_in_h = 18'o001000; c_in_h = 2'b00; paren = 1'b1; msyn_in_h = 1'b1;
        k = 0;
        for (int i = 0; i < 30 && !ssyn_out_h; i++) @(negedge CLOCK);
        chk("init_reach_ssyn", ssyn_out_h, 1);
        init_in_h = 1'b1;
        @(negedge CLOCK);
        init_in_h = 1'b0;
        dropped = !ssyn_out_h && d_out_h == 16'd0;
        k = 1;
        while (!dropped && k < 10) begin
            @(negedge CLOCK);
            k++;
            dropped = !ssyn_out_h && d_out_h == 16'd0;
        end
        chk("init_drop_cycles", (k <= 3), 1);
        e0 = enab_total;
        repeat (15) @(negedge CLOCK);
        chk("init_no_retrigger", enab_total - e0, 0);
        chk("init_ssyn_low", ssyn_out_h, 0);
        msyn_in_h = 1'b0;
        repeat (6) @(negedge CLOCK);
        chk("init_keeps_errcnt", parerrcnt, 1);
        bus_cycle(18'o001000, 2'b00, 16'o0, 1, 1);
        chk("post_init_ssyn", r_got, 1);
        chk("post_init_data", r_d, 16'o177511);
        $display("init seq: drop after %0d cycles, next read d=%06o", k, r_d);

        // MSYN held for many cycles: one access, one SSYN.
        e0 = enab_total; r0 = ssyn_rises;
        @(negedge CLOCK);
        a_in_h = 18'o001000; c_in_h = 2'b00; msyn_in_h = 1'b1;
        repeat (40) @(negedge CLOCK);
        chk("hold_ssyn_high", ssyn_out_h, 1);
        msyn_in_h = 1'b0;
        repeat (8) @(negedge CLOCK);
        chk("hold_one_access", enab_total - e0, 1);
        chk("hold_one_ssyn", ssyn_rises - r0, 1);
        $display("hold seq: accesses=%0d ssyn_rises=%0d", enab_total - e0, ssyn_rises - r0);

        // Master abort during DRIVE on a write: RAM written, no SSYN.
        e0 = enab_total; r0 = ssyn_rises;
        @(negedge CLOCK);
        a_in_h = 18'o001000; c_in_h = 2'b10; d_in_h = 16'o016161; msyn_in_h = 1'b1;
        repeat (5) @(negedge CLOCK);
        msyn_in_h = 1'b0;
        repeat (15) @(negedge CLOCK);
        chk("abort_access", enab_total - e0, 1);
        chk("abort_no_ssyn", ssyn_rises - r0, 0);
        bus_cycle(18'o001000, 2'b00, 16'o0, 1, 1);
        chk("abort_readback", r_d, 16'o016161);
        $display("abort seq: readback d=%06o", r_d);

        // Randomized cycles over a preloaded 16-word window.
        for (int n = 0; n < 150; n++) begin
            int          idx;
            logic [17:0] a;
            logic [1:0]  c;
            logic [15:0] d;
            logic        p, en;
            idx = $urandom_range(0, 15);
            a   = 18'o002000 + 18'(idx * 2) + 18'($urandom_range(0, 1));
            c   = 2'($urandom_range(0, 3));
            d   = 16'($urandom);
            p   = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 7) != 0);
            bus_cycle(a, c, d, p, en);
            chk($sformatf("rnd%0d_ssyn", n), r_got, en);
            chk($sformatf("rnd%0d_enab", n), r_nenab, en ? 1 : 0);
            if (en && !c[1]) begin
                chk($sformatf("rnd%0d_data", n), r_d, ref_word[idx]);
                chk($sformatf("rnd%0d_pa", n), r_pa, 0);
            end else if (en) begin
                if (c == 2'b10)      ref_word[idx] = d;
                else if (a[0])       ref_word[idx][15:8] = d[15:8];
                else                 ref_word[idx][7:0] = d[7:0];
            end
            $display("rnd %0d a=%06o c=%0d en=%0d -> ssyn=%0d d=%06o", n, a, c, en, r_got, r_d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
